irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Interrupt controller that consumes the sticky outputs of a bank of `flag_register` instances and produces the single interrupt request to the darkriscv core. It masks and priority-encodes the pending flags, exposes them through a 4-word memory-mapped register window, and generates the per-flag `clear` pulses that the flag registers need when software acknowledges an event. It sits between the peripheral flag bank and the core's interrupt input.

## Interface
- `NIRQ`, 8: number of flag inputs; legal range 1..32.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flags`  in  NIRQ  sticky flags from the flag registers (`flag_out`); already synchronous to `clk`.
- `clear`  out  NIRQ  one-cycle clear pulses to the flag registers (`clear`).
- `irq`  out  1  interrupt request to the core, registered.
- `bus_sel`  in  1  register window selected.
- `bus_wr`  in  1  1 = write, 0 = read; valid with `bus_sel`.
- `bus_addr`  in  2  word address: 0 PENDING, 1 MASK, 2 CLAIM, 3 CLEAR.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data; valid only while `bus_ack` = 1, otherwise 0.
- `bus_ack`  out  1  one-cycle acknowledge.

## Operation
- PENDING (RO): zero-extended `flags`. MASK (RW): bit i = 1 enables flag i; bits ≥ NIRQ read 0. CLEAR (W1C): bit i = 1 pulses `clear[i]`. Writes to PENDING and CLAIM are acknowledged and ignored. Reads of CLEAR return 0.
- `active = flags & mask`. Winner = lowest set index of `active`, so index 0 has the highest priority.
- FSM states: IDLE, ASSERT, SERVICE, DRAIN.
  - IDLE: `irq` = 0. If `active` ≠ 0, go to ASSERT.
  - ASSERT: `irq` = 1. On a CLAIM read, latch the winner as `claim_id` and go to SERVICE. If `active` drops to 0 first (masked by software), return to IDLE.
  - SERVICE: `irq` = 0. On a CLEAR write with bit `claim_id` set, go to DRAIN. Other CLEAR bits still pulse but cause no state change.
  - DRAIN: `irq` = 0 for exactly 2 cycles, then IDLE. This covers the clear-to-flag-low latency so a stale flag is not re-signalled.
- CLAIM read returns `{valid, 26'b0, id[4:0]}`:
  - valid = 1 with the winner only in ASSERT.
  - Otherwise returns 0 and leaves the state unchanged.
- The winner is sampled on the cycle the CLAIM read is accepted.
- Reset values: `irq` = 0, `clear` = 0, `bus_ack` = 0, `bus_rdata` = 0, `mask` = 0, `claim_id` = 0, state = IDLE.
- Reset asserted mid-operation aborts any pending `clear` pulse and returns the FSM to IDLE asynchronously.

## Timing
- Bus: a request is accepted on an edge where `bus_sel` = 1 and `bus_ack` = 0. `bus_ack` and `bus_rdata` are registered and appear in the next cycle. Back-to-back `bus_sel` yields an ack every other cycle.
- MASK write takes effect on `active` one cycle after acceptance.
- CLEAR write accepted at edge T:
  - `clear` is high during cycle T+1 only.
  - The flag is low from cycle T+2.
  - DRAIN occupies cycles T+1 and T+2; the FSM is in IDLE at T+3.
- `irq` rises one cycle after `active` becomes nonzero in IDLE, and falls in the cycle after a CLAIM read is accepted.
- A flag setting in the same cycle its `clear` pulse is active is lost, because `clear` has priority in `flag_register`. This is accepted behaviour.

## Structure
- Shared package `irq_pkg`: register offsets (`IRQ_PENDING`=0, `IRQ_MASK`=1, `IRQ_CLAIM`=2, `IRQ_CLEAR`=3), FSM state encoding, and CLAIM valid-bit position (31).
- One sub-module `irq_prio_enc` (parameterised on width): combinational lowest-index encoder producing `any` and `id[4:0]`.
- FSM, bus decode and register storage live in `irq_ctrl`.

## Test plan
- Reset: hold `rst_n` = 0 with `flags` = 8'hFF → `irq` = 0, MASK reads 0, `clear` = 0; after release `irq` stays 0 because the mask is 0.
- Priority claim: MASK = 8'h14, `flags` = 8'h1C → `irq` = 1; CLAIM reads 32'h8000_0002; `irq` = 0 the next cycle.
- Clear and drain: after the claim above, write CLEAR = 8'h04 → `clear` = 8'h04 for one cycle; model drops flag 2; `irq` returns to 1 at T+4; CLAIM reads 32'h8000_0004.
- Non-claimed clear: in SERVICE with `claim_id` = 2, write CLEAR = 8'h10 → `clear[4]` pulses, state stays SERVICE, `irq` stays 0.
- Mask withdraw: in ASSERT with MASK = 8'h01 and `flags` = 8'h01, write MASK = 0 → back to IDLE, `irq` = 0; CLAIM reads 0.
- Reset mid-operation: assert `rst_n` = 0 during the `clear` cycle → `clear` drops immediately, state is IDLE, MASK = 0.

Source files
------------

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_pkg
// Purpose  : Shared register offsets, FSM state encoding and CLAIM word layout
//            for the interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package irq_pkg;

  // Word offsets inside the 4-word register window
  localparam logic [1:0] IRQ_PENDING = 2'd0;
  localparam logic [1:0] IRQ_MASK    = 2'd1;
  localparam logic [1:0] IRQ_CLAIM   = 2'd2;
  localparam logic [1:0] IRQ_CLEAR   = 2'd3;

  // Controller FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  // Position of the valid flag in the CLAIM read word
  localparam int CLAIM_VALID_BIT = 31;

  typedef logic [1:0] irq_addr_t;

  // Build the CLAIM read word: {valid, zeros, id[4:0]}
  function automatic logic [31:0] claim_word(input logic valid, input logic [4:0] id);
    logic [31:0] w;
    w                  = '0;
    w[CLAIM_VALID_BIT] = valid;
    w[4:0]             = id;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_enc
// Purpose  : Combinational lowest-index priority encoder. Index 0 wins.
// Revision : 1.0 - initial release
// ============================================================================
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req,
  output logic             any,
  output logic [4:0]       id
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    any = |req;
    id  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        id = 5'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Masks and priority-encodes sticky peripheral flags, drives the
//            core interrupt request, and exposes PENDING/MASK/CLAIM/CLEAR
//            through a small register window with one-cycle clear pulses.
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NIRQ = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NIRQ-1:0] flags,
  output logic [NIRQ-1:0] clear,
  output logic            irq,
  input  logic            bus_sel,
  input  logic            bus_wr,
  input  logic [1:0]      bus_addr,
  input  logic [31:0]     bus_wdata,
  output logic [31:0]     bus_rdata,
  output logic            bus_ack
);

  logic [NIRQ-1:0] mask;
  logic [NIRQ-1:0] active;
  logic            any;
  logic [4:0]      win_id;

  logic [1:0]      state;
  logic [1:0]      next_state;
  logic [4:0]      claim_id;
  logic            drain_cnt;

  irq_addr_t       addr;
  logic            accept;
  logic            mask_wr;
  logic            clear_wr;
  logic            claim_rd;
  logic            claim_hit;
  logic [31:0]     flags_ext;
  logic [31:0]     mask_ext;
  logic [31:0]     rdata_next;

  assign active = flags & mask;

  irq_prio_enc #(
    .WIDTH (NIRQ)
  ) u_prio (
    .req (active),
    .any (any),
    .id  (win_id)
  );

  // A request is taken only while no ack is outstanding, so a held select
  // yields one ack every other cycle.
  assign addr      = bus_addr;
  assign accept    = bus_sel & ~bus_ack;
  assign mask_wr   = accept &  bus_wr & (addr == IRQ_MASK);
  assign clear_wr  = accept &  bus_wr & (addr == IRQ_CLEAR);
  assign claim_rd  = accept & ~bus_wr & (addr == IRQ_CLAIM);
  assign claim_hit = claim_rd & (state == ST_ASSERT) & any;

  // Read data mux: zero-extended flag/mask views and the CLAIM word
  always_comb begin
    flags_ext             = '0;
    flags_ext[NIRQ-1:0]   = flags;
    mask_ext              = '0;
    mask_ext[NIRQ-1:0]    = mask;
    rdata_next            = '0;
    if (accept && !bus_wr) begin
      case (addr)
        IRQ_PENDING: rdata_next = flags_ext;
        IRQ_MASK:    rdata_next = mask_ext;
        IRQ_CLAIM:   rdata_next = (state == ST_ASSERT && any) ? claim_word(1'b1, win_id) : '0;
        default:     rdata_next = '0;
      endcase
    end
  end

  // Next-state logic for the assert / service / drain handshake
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (any) next_state = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (claim_hit)   next_state = ST_SERVICE;
        else if (!any)   next_state = ST_IDLE;
      end
      ST_SERVICE: begin
        // Only acknowledging the claimed source ends service
        if (clear_wr && bus_wdata[claim_id]) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Two quiet cycles let the cleared flag fall before re-arbitration
        if (drain_cnt) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM state, drain counter, claimed id and registered irq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      drain_cnt <= 1'b0;
      claim_id  <= '0;
      irq       <= 1'b0;
    end else begin
      state     <= next_state;
      drain_cnt <= (state == ST_DRAIN);
      if (claim_hit) claim_id <= win_id;
      irq       <= (next_state == ST_ASSERT);
    end
  end

  // Mask register and one-cycle clear pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask  <= '0;
      clear <= '0;
    end else begin
      if (mask_wr) mask <= bus_wdata[NIRQ-1:0];
      clear <= clear_wr ? bus_wdata[NIRQ-1:0] : '0;
    end
  end

  // Registered bus response; data is zero whenever no ack is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack   <= accept;
      bus_rdata <= rdata_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl
// Purpose  : Self-checking bench for irq_ctrl with a flag-register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;
  import irq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  flags;
  logic [7:0]  clear;
  logic        irq;
  logic        bus_sel;
  logic        bus_wr;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  irq_ctrl #(.NIRQ(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flags     (flags),
    .clear     (clear),
    .irq       (irq),
    .bus_sel   (bus_sel),
    .bus_wr    (bus_wr),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sticky flag bank model: clear wins over everything, load forces a value
  logic       load_en;
  logic [7:0] load_val;
  always @(posedge clk) begin
    if (load_en) flags <= load_val;
    else         flags <= flags & ~clear;
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic        chk;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  flg;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_flags(input logic [7:0] v);
    @(negedge clk);
    load_val = v;
    load_en  = 1'b1;
    @(posedge clk);
    #1;
    load_en  = 1'b0;
  endtask

  // One bus access; returns in the cycle where its ack is visible
  task automatic bus_op(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    bus_sel   = 1'b1;
    bus_wr    = wr;
    bus_addr  = addr;
    bus_wdata = wdata;
    e.name = name;
    e.chk  = !wr;
    e.exp  = exp;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bus_sel   = 1'b0;
    bus_wr    = 1'b0;
    bus_wdata = '0;
    @(negedge clk);
    #2;
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL %s_ack: got no ack, expected ack one cycle after request", name);
      sbq.delete();
    end
  endtask

  // Scoreboard consumer: every ack pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_ack === 1'b1) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ack: got ack with rdata %h, expected no ack", bus_rdata);
        end else begin
          e = sbq.pop_front();
          if (e.chk) check(e.name, bus_rdata, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end within time budget");
    $fatal(1);
  end

  initial begin
    // Register-window vectors: {wr, addr, wdata, flags, expected read}
    tbl[0]  = '{1'b0, IRQ_PENDING, 32'h0,         8'h00, 32'h0000_0000};
    tbl[1]  = '{1'b0, IRQ_PENDING, 32'h0,         8'h5A, 32'h0000_005A};
    tbl[2]  = '{1'b1, IRQ_MASK,    32'hFFFF_FF81, 8'h00, 32'h0};
    tbl[3]  = '{1'b0, IRQ_MASK,    32'h0,         8'h00, 32'h0000_0081};
    tbl[4]  = '{1'b1, IRQ_PENDING, 32'hFFFF_FFFF, 8'h3C, 32'h0};
    tbl[5]  = '{1'b0, IRQ_PENDING, 32'h0,         8'h3C, 32'h0000_003C};
    tbl[6]  = '{1'b0, IRQ_CLEAR,   32'h0,         8'h3C, 32'h0000_0000};
    tbl[7]  = '{1'b1, IRQ_CLAIM,   32'hFFFF_FFFF, 8'h3C, 32'h0};
    tbl[8]  = '{1'b0, IRQ_CLAIM,   32'h0,         8'h3C, 32'h0000_0000};
    tbl[9]  = '{1'b0, IRQ_MASK,    32'h0,         8'h3C, 32'h0000_0081};
    tbl[10] = '{1'b1, IRQ_MASK,    32'h0,         8'h00, 32'h0};
    tbl[11] = '{1'b0, IRQ_MASK,    32'h0,         8'h00, 32'h0000_0000};

    rst_n     = 1'b0;
    bus_sel   = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    load_en   = 1'b0;
    load_val  = '0;

    // Reset with all flags high
    set_flags(8'hFF);
    @(negedge clk);
    check("rst_irq",   {31'b0, irq},     32'h0);
    check("rst_clear", {24'b0, clear},   32'h0);
    check("rst_ack",   {31'b0, bus_ack}, 32'h0);
    check("rst_rdata", bus_rdata,        32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_irq", {31'b0, irq}, 32'h0);
    bus_op(1'b0, IRQ_MASK, 32'h0, 32'h0, "post_rst_mask");

    // Table-driven register window checks
    for (int i = 0; i < 12; i++) begin
      set_flags(tbl[i].flg);
      bus_op(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, 32'h0);
    end

    // Back-to-back select: two acks over four edges
    set_flags(8'h33);
    @(negedge clk);
    bus_sel  = 1'b1;
    bus_wr   = 1'b0;
    bus_addr = IRQ_PENDING;
    sbq.push_back('{"b2b_a", 1'b1, 32'h0000_0033});
    sbq.push_back('{"b2b_b", 1'b1, 32'h0000_0033});
    repeat (4) @(posedge clk);
    #1;
    bus_sel = 1'b0;
    @(negedge clk);
    #2;
    check("b2b_pending", sbq.size(), 32'h0);
    sbq.delete();

    // Priority claim: flags 1C masked by 14 -> winner 2
    set_flags(8'h1C);
    bus_op(1'b1, IRQ_MASK, 32'h14, 32'h0, "pc_mask");
    @(posedge clk);
    #1;
    check("pc_irq_high", {31'b0, irq}, 32'h1);
    bus_op(1'b0, IRQ_CLAIM, 32'h0, 32'h8000_0002, "pc_claim");
    check("pc_irq_low", {31'b0, irq}, 32'h0);

    // Non-claimed clear in SERVICE
    bus_op(1'b1, IRQ_CLEAR, 32'h10, 32'h0, "nc_clear");
    check("nc_pulse", {24'b0, clear}, 32'h10);
    @(posedge clk);
    #1;
    check("nc_pulse_end", {24'b0, clear}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("nc_irq", {31'b0, irq}, 32'h0);
    bus_op(1'b0, IRQ_CLAIM, 32'h0, 32'h0, "nc_claim_svc");

    // Claimed clear and drain: re-assert at T+4 with flag 4
    set_flags(8'h1C);
    bus_op(1'b1, IRQ_CLEAR, 32'h04, 32'h0, "cd_clear");
    check("cd_pulse", {24'b0, clear}, 32'h04);
    check("cd_irq_t1", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("cd_pulse_end", {24'b0, clear}, 32'h0);
    check("cd_irq_t2", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("cd_irq_t3", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("cd_irq_t4", {31'b0, irq}, 32'h1);
    bus_op(1'b0, IRQ_CLAIM, 32'h0, 32'h8000_0004, "cd_claim");
    check("cd_irq_low", {31'b0, irq}, 32'h0);
    bus_op(1'b1, IRQ_CLEAR, 32'h10, 32'h0, "cd_clear4");
    repeat (4) @(posedge clk);
    #1;
    check("cd_idle_irq", {31'b0, irq}, 32'h0);

    // Mask withdraw while asserting
    set_flags(8'h01);
    bus_op(1'b1, IRQ_MASK, 32'h01, 32'h0, "mw_mask1");
    @(posedge clk);
    #1;
    check("mw_irq_high", {31'b0, irq}, 32'h1);
    bus_op(1'b1, IRQ_MASK, 32'h00, 32'h0, "mw_mask0");
    @(posedge clk);
    #1;
    check("mw_irq_low", {31'b0, irq}, 32'h0);
    bus_op(1'b0, IRQ_CLAIM, 32'h0, 32'h0, "mw_claim");

    // Reset during the clear pulse
    set_flags(8'h03);
    bus_op(1'b1, IRQ_MASK, 32'h03, 32'h0, "rm_mask");
    @(posedge clk);
    #1;
    check("rm_irq_high", {31'b0, irq}, 32'h1);
    bus_op(1'b0, IRQ_CLAIM, 32'h0, 32'h8000_0000, "rm_claim");
    bus_op(1'b1, IRQ_CLEAR, 32'h01, 32'h0, "rm_clear");
    check("rm_pulse", {24'b0, clear}, 32'h01);
    rst_n = 1'b0;
    #1;
    check("rm_clear_drop", {24'b0, clear}, 32'h0);
    check("rm_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_op(1'b0, IRQ_MASK, 32'h0, 32'h0, "rm_mask_rd");
    bus_op(1'b1, IRQ_MASK, 32'h03, 32'h0, "rm_mask2");
    @(posedge clk);
    #1;
    check("rm_idle_reassert", {31'b0, irq}, 32'h1);
    bus_op(1'b0, IRQ_CLAIM, 32'h0, 32'h8000_0000, "rm_claim2");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
